// File: rtl/rs_pkg.sv
// Shared types for the RS flip-flop command driver: FSM states and the
// {set, reset} encodings presented to the flop.
package rs_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PULSE,
    CHECK,
    GAP
  } state_t;

  // Bit order is {set, reset}; the 11 encoding must never reach the flop.
  localparam logic [1:0] RS_HOLD    = 2'b00;
  localparam logic [1:0] RS_RESET   = 2'b01;
  localparam logic [1:0] RS_SET     = 2'b10;
  localparam logic [1:0] RS_ILLEGAL = 2'b11;

endpackage

// File: rtl/rs_cmd_driver_if.sv
// Request handshake between control logic (master) and the RS-FF command
// driver (slave). The done pulse travels back to the requester.
interface rs_cmd_driver_if;

  logic req_valid;
  logic req_level;
  logic req_force;
  logic req_ready;
  logic done;

  modport master (
    output req_valid, req_level, req_force,
    input  req_ready, done
  );

  modport slave (
    input  req_valid, req_level, req_force,
    output req_ready, done
  );

endinterface

// File: rtl/rs_pulse_timer.sv
// Loadable down-counter used to time both the Set/Reset pulse and the idle gap.
module rs_pulse_timer #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clock) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  // Count holds the cycles remaining including the current one, so the
  // final cycle of a loaded interval is the one where count is 1.
  assign zero = (count <= CNT_W'(1));

endmodule

// File: rtl/rs_cmd_driver.sv
// Converts "make q = level" requests into legal, timed Set/Reset pulses for one
// RS flip-flop, tracks the flop in a shadow register and checks its feedback.
module rs_cmd_driver
  import rs_pkg::*;
#(
  parameter int unsigned PULSE_CYCLES = 1,
  parameter int unsigned GAP_CYCLES   = 1,
  parameter int unsigned CNT_W        = 8
) (
  input  logic             clock,
  input  logic             reset,
  rs_cmd_driver_if.slave   cmd,
  output logic             set_out,
  output logic             reset_out,
  input  logic             q_in,
  input  logic             q_bar_in,
  output logic             err,
  output logic             shadow_q,
  output logic             shadow_valid
);

  state_t           state;
  state_t           state_next;
  logic             cmd_level;
  logic             accept;
  logic             skip;
  logic             drive_level;
  logic             done_r;
  logic             timer_load;
  logic [CNT_W-1:0] timer_val;
  logic             timer_zero;

  rs_pulse_timer #(.CNT_W(CNT_W)) u_timer (
    .clock    (clock),
    .reset    (reset),
    .load     (timer_load),
    .load_val (timer_val),
    .zero     (timer_zero)
  );

  assign cmd.req_ready = (state == IDLE);
  assign cmd.done      = done_r;
  assign accept        = cmd.req_valid && cmd.req_ready;
  // A request is redundant only when the shadow is known-good and not overridden.
  assign skip          = shadow_valid && !cmd.req_force && (cmd.req_level == shadow_q);
  assign drive_level   = (state == IDLE) ? cmd.req_level : cmd_level;

  // Next-state decode; also loads the shared timer for the PULSE and GAP phases.
  always_comb begin
    state_next = state;
    timer_load = 1'b0;
    timer_val  = '0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (skip) begin
            state_next = CHECK;
          end else begin
            state_next = PULSE;
            timer_load = 1'b1;
            timer_val  = CNT_W'(PULSE_CYCLES);
          end
        end
      end
      PULSE: begin
        if (timer_zero) state_next = CHECK;
      end
      CHECK: begin
        if (GAP_CYCLES > 0) begin
          state_next = GAP;
          timer_load = 1'b1;
          timer_val  = CNT_W'(GAP_CYCLES);
        end else begin
          state_next = IDLE;
        end
      end
      GAP: begin
        if (timer_zero) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Set/Reset and done are registered from the next state so the flop never
  // sees a combinational path from the request inputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      cmd_level    <= 1'b0;
      set_out      <= 1'b0;
      reset_out    <= 1'b0;
      done_r       <= 1'b0;
      err          <= 1'b0;
      shadow_q     <= 1'b0;
      shadow_valid <= 1'b0;
    end else begin
      state  <= state_next;
      done_r <= (state_next == CHECK);
      if (state_next == PULSE) begin
        {set_out, reset_out} <= drive_level ? RS_SET : RS_RESET;
      end else begin
        {set_out, reset_out} <= RS_HOLD;
      end
      if (state == IDLE && accept && !skip) begin
        cmd_level <= cmd.req_level;
      end
      if (state == PULSE && timer_zero) begin
        shadow_q     <= cmd_level;
        shadow_valid <= 1'b1;
      end
      if (state == CHECK && (q_in != shadow_q || q_in == q_bar_in)) begin
        err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_rs_cmd_driver.sv
// Scoreboard bench for rs_cmd_driver driving a behavioural RS flip-flop.
module tb_rs_cmd_driver;
  import rs_pkg::*;

  localparam int P = 2;
  localparam int G = 1;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic set_out, reset_out, q_in, q_bar_in, err, shadow_q, shadow_valid;
  logic q_ff = 1'b0;
  logic tie_q0 = 1'b0;

  int cyc = 0;
  int vectors = 0;
  int miscompares = 0;
  int accepts = 0;
  int dones = 0;

  typedef struct {
    bit pulse;
    bit level;
    bit shadow;
    bit err;
    int acc;
  } exp_t;
  exp_t exp_q[$];

  // Reference model: what the flop and driver should believe after each command.
  bit m_shadow = 0, m_valid = 0, m_err = 0, m_q = 0;
  bit last_pulse = 0;
  int last_acc = 0;

  bit err_pending = 0, err_exp = 0;
  int set_cnt = 0, rst_cnt = 0;

  rs_cmd_driver_if cmd();

  rs_cmd_driver #(.PULSE_CYCLES(P), .GAP_CYCLES(G), .CNT_W(8)) dut (
    .clock        (clock),
    .reset        (reset),
    .cmd          (cmd.slave),
    .set_out      (set_out),
    .reset_out    (reset_out),
    .q_in         (q_in),
    .q_bar_in     (q_bar_in),
    .err          (err),
    .shadow_q     (shadow_q),
    .shadow_valid (shadow_valid)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc++;

  // The RS flop under control: no reset, holds on 00.
  always @(posedge clock) begin
    if (set_out && !reset_out) q_ff <= 1'b1;
    else if (reset_out && !set_out) q_ff <= 1'b0;
  end
  assign q_in     = tie_q0 ? 1'b0 : q_ff;
  assign q_bar_in = ~q_ff;

  task automatic check_output(string name, int act, int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic issue(bit level, bit frc, output bit ok);
    int n;
    exp_t e;
    bit obs_q;
    n = 0;
    cmd.req_level = level;
    cmd.req_force = frc;
    cmd.req_valid = 1'b1;
    while (!cmd.req_ready && n < 50) begin
      @(negedge clock);
      n++;
    end
    if (!cmd.req_ready) begin
      check_output("accept_timeout", 0, 1);
      ok = 0;
      return;
    end
    e.pulse = !(m_valid && !frc && level == m_shadow);
    if (e.pulse) begin
      m_shadow = level;
      m_valid  = 1;
      m_q      = level;
    end
    obs_q = tie_q0 ? 1'b0 : m_q;
    if (obs_q != m_shadow || obs_q == !m_q) m_err = 1;
    e.level  = level;
    e.shadow = m_shadow;
    e.err    = m_err;
    e.acc    = cyc + 1;
    exp_q.push_back(e);
    accepts++;
    last_pulse = e.pulse;
    last_acc   = e.acc;
    @(negedge clock);
    ok = 1;
  endtask

  task automatic apply_stimulus(bit level, bit frc, bit hold);
    bit ok;
    int n;
    issue(level, frc, ok);
    if (!hold) cmd.req_valid = 1'b0;
    if (ok) begin
      n = 0;
      while (!cmd.req_ready && n < 50) begin
        @(negedge clock);
        n++;
      end
      check_output("ready_latency", cyc - last_acc, last_pulse ? P + 1 + G : 1 + G);
    end
  endtask

  // Called at a negedge; one reset edge, returns at a negedge with reset low.
  task automatic do_reset();
    reset = 1'b1;
    @(negedge clock);
    #2 reset = 1'b0;
    exp_q.delete();
    m_valid = 0;
    m_shadow = 0;
    m_err = 0;
    @(negedge clock);
  endtask

  // Monitor: pops one expectation per done pulse and checks it.
  always @(negedge clock) begin
    exp_t e;
    if (reset) begin
      set_cnt = 0;
      rst_cnt = 0;
      err_pending = 0;
    end else begin
      check_output("set_reset_exclusive", int'({set_out, reset_out} == RS_ILLEGAL), 0);
      if (err_pending) begin
        check_output("err_after_check", err, err_exp);
        err_pending = 0;
      end
      if (set_out) set_cnt++;
      if (reset_out) rst_cnt++;
      if (cmd.done) begin
        dones++;
        if (exp_q.size() == 0) begin
          check_output("unexpected_done", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check_output("set_width", set_cnt, (e.pulse && e.level) ? P : 0);
          check_output("reset_width", rst_cnt, (e.pulse && !e.level) ? P : 0);
          check_output("done_latency", cyc - e.acc, e.pulse ? P : 0);
          check_output("shadow_q", shadow_q, e.shadow);
          check_output("shadow_valid", shadow_valid, 1);
          err_pending = 1;
          err_exp = e.err;
        end
        set_cnt = 0;
        rst_cnt = 0;
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    bit ok;
    cmd.req_valid = 1'b0;
    cmd.req_level = 1'b0;
    cmd.req_force = 1'b0;
    repeat (3) @(negedge clock);
    #2 reset = 1'b0;
    @(negedge clock);
    check_output("rst_set_out", set_out, 0);
    check_output("rst_reset_out", reset_out, 0);
    check_output("rst_done", cmd.done, 0);
    check_output("rst_err", err, 0);
    check_output("rst_shadow_q", shadow_q, 0);
    check_output("rst_shadow_valid", shadow_valid, 0);
    check_output("rst_ready", cmd.req_ready, 1);

    apply_stimulus(1, 0, 0);
    check_output("q_after_set", q_ff, 1);
    apply_stimulus(1, 0, 0);
    apply_stimulus(1, 1, 0);
    apply_stimulus(0, 0, 0);
    check_output("q_after_reset", q_ff, 0);
    check_output("q_bar_after_reset", q_bar_in, 1);
    check_output("err_clean", err, 0);

    tie_q0 = 1'b1;
    apply_stimulus(1, 0, 0);
    tie_q0 = 1'b0;
    check_output("err_on_bad_feedback", err, 1);
    apply_stimulus(0, 0, 0);
    apply_stimulus(1, 0, 0);
    check_output("err_sticky_later", err, 1);

    do_reset();
    check_output("err_cleared_by_reset", err, 0);

    // Abort a command during its first pulse cycle.
    issue(1, 0, ok);
    cmd.req_valid = 1'b0;
    check_output("pulse_started", set_out, 1);
    reset = 1'b1;
    @(negedge clock);
    check_output("abort_set_out", set_out, 0);
    check_output("abort_shadow_valid", shadow_valid, 0);
    check_output("abort_ready", cmd.req_ready, 1);
    #2 reset = 1'b0;
    exp_q.delete();
    if (ok) accepts--;
    m_valid = 0;
    m_shadow = 0;
    m_err = 0;
    m_q = 1;
    @(negedge clock);
    apply_stimulus(0, 0, 0);
    check_output("q_after_abort_redrive", q_ff, 0);

    for (int i = 0; i < 40; i++) begin
      apply_stimulus(1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0), 1);
    end
    cmd.req_valid = 1'b0;

    repeat (5) @(negedge clock);
    check_output("done_count", dones, accepts);
    check_output("scoreboard_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
